// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, optional even parity.
// Build-time option: define UART_RX_PARITY_EN to add an even-parity bit after the data
// bits (8E1). Without it the frame is 8N1 and parity_err is tied low.
module uart_rx #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e        state_q, state_d;
  logic          rx_meta_q, rxs_q, rxs_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          par_bad;

`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // State, bit timer, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic: sample mid-start after half a bit, then every full bit period.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        timer_d  = '0;
        bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (rxs_prev_q && !rxs_q) state_d = StStart;
      end
      StStart: begin
        if (timer_q == TW'(HALF_BIT - 1)) begin
          timer_d = '0;
          // Line back high at mid-start: treat as a glitch.
          state_d = rxs_q ? StIdle : StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d  = '0;
          shift_d  = {rxs_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          // Even parity: parity bit equals XOR of the data bits.
          if (rxs_q != ^shift_q) begin
            perr_d    = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = StStop;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          if (rxs_q) begin
            if (!par_bad) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            // A parity-failed frame already reported its one error pulse.
            ferr_d  = !par_bad;
            state_d = StBreak;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (104 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  int n_excl  = 0;
  logic [7:0] rxq[$];

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count output pulses (in cycles high) away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      rxq.push_back(data);
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) n_excl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Caller must be at a negedge; returns at a negedge so frames can abut.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_clks);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b, CPB);
`endif
    drive_bit(stop_val, stop_clks);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic par);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(par, CPB);
    drive_bit(1'b1, CPB);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, f0, p0, q0;

    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame 0xA5.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_byte(8'hA5, 1'b1, CPB);
    check("a5_valid", n_valid - v0, 1);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_busy", {31'd0, busy}, 32'd0);
    check("a5_ferr", n_ferr - f0, 0);
    check("a5_perr", n_perr - p0, 0);

    // Start-bit glitch: 30 clocks low.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_data", {24'd0, data}, 32'hA5);

    // Stop bit held low: framing error, then break until line idles.
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h3C, 1'b0, 500);
    check("brk_ferr", n_ferr - f0, 1);
    check("brk_valid", n_valid - v0, 0);
    check("brk_data", {24'd0, data}, 32'hA5);
    check("brk_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_busy_lo", {31'd0, busy}, 32'd0);
    v0 = n_valid;
    send_byte(8'h81, 1'b1, CPB);
    check("after_brk_valid", n_valid - v0, 1);
    check("after_brk_data", {24'd0, data}, 32'h81);

    // Back-to-back frames, no idle gap.
    v0 = n_valid; q0 = rxq.size();
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'hFF, 1'b1, CPB);
    send_byte(8'h55, 1'b1, CPB);
    check("b2b_count", n_valid - v0, 3);
    if (rxq.size() >= q0 + 3) begin
      check("b2b_d0", {24'd0, rxq[q0]}, 32'h00);
      check("b2b_d1", {24'd0, rxq[q0+1]}, 32'hFF);
      check("b2b_d2", {24'd0, rxq[q0+2]}, 32'h55);
    end else begin
      check("b2b_queue", rxq.size() - q0, 3);
    end

    // Reset in the middle of bit 4 of 0x96.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i), CPB);
    drive_bit(1'(8'h96 >> 4), CPB / 2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_data", {24'd0, data}, 32'h00);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    check("mid_rst_pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    send_byte(8'h69, 1'b1, CPB);
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_data", {24'd0, data}, 32'h69);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_par(8'h07, 1'b1);
    check("par_ok_valid", n_valid - v0, 1);
    check("par_ok_data", {24'd0, data}, 32'h07);
    v0 = n_valid; p0 = n_perr;
    send_par(8'h07, 1'b0);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_valid", n_valid - v0, 0);
    check("par_bad_ferr", n_ferr - f0, 0);
    check("par_bad_data", {24'd0, data}, 32'h07);
`endif

    check("pulse_exclusive", n_excl, 0);
    check("no_par_pulses", n_perr,
`ifdef UART_RX_PARITY_EN
          1
`else
          0
`endif
    );

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division (104 at defaults).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port data  output  8  last correctly received byte.
REQ-007 SHALL have port valid  output  1  one-cycle pulse, data updated this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: falling edge of rxs (prev 1, now 0) -> START, bit-timer cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rxs; 0 -> DATA with timer cleared, 1 -> IDLE (glitch rejected, no pulses).
REQ-015 DATA: sample rxs every CLKS_PER_BIT cycles; 8 bits, LSB first, into shift register; after 8th sample -> PARITY if enabled, else STOP.
REQ-016 STOP: sample rxs after CLKS_PER_BIT cycles; 1 -> latch data, pulse valid, -> IDLE; 0 -> pulse frame_err, data unchanged, -> BREAK.
REQ-017 BREAK: stay until rxs = 1, then -> IDLE; no new start detected while in BREAK.
REQ-018 Latency: valid asserts one clk after the stop-bit mid-sample edge, i.e. ~9.5 bit times (10.5 with parity) after start falling edge plus 2 synchronizer cycles.
REQ-019 valid, frame_err, parity_err SHALL be mutually exclusive and each high for exactly one cycle per frame.
REQ-020 Back-to-back frames: a start edge arriving the cycle after return to IDLE SHALL be detected (no dead cycle beyond edge detection).
REQ-021 Bit timer SHALL be wide enough for CLKS_PER_BIT-1 and wrap to 0 on each sample.
REQ-022 data SHALL hold its value between frames and across errored frames.

Reset
REQ-023 rst high SHALL force, asynchronously: state IDLE, data 0x00, valid 0, frame_err 0, parity_err 0, busy 0, timer 0, bit count 0, synchronizer flops 1.
REQ-024 Reset mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-026 With UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after DATA; mismatch -> pulse parity_err, data unchanged, -> STOP (frame checked, but no valid or frame_err pulse for that frame); match -> STOP with normal handling.
REQ-027 Without UART_RX_PARITY_EN: PARITY state not built, frame is 8N1, parity_err tied 0.

Verification
REQ-028 Defaults, no parity: send 0xA5 at 104 clk/bit -> one valid pulse, data=0xA5, busy low after stop, no error pulses.
REQ-029 rx low for 30 clks then high -> no pulses, busy returns low, data unchanged.
REQ-030 Send 0x3C with stop bit held low 500 clks -> one frame_err pulse, data keeps prior value, busy high until rx high, then next 0x81 -> valid, data=0x81.
REQ-031 Frames 0x00, 0xFF, 0x55 sent with zero idle gap -> three valid pulses, data in order.
REQ-032 Assert rst during bit 4 of 0x96 -> outputs at reset values immediately; following 0x69 received correctly.
REQ-033 UART_RX_PARITY_EN: 0x07 with parity 1 -> valid, data=0x07; with parity 0 -> parity_err pulse, data unchanged.
